// File: rtl/gray_count_receiver.sv
`default_nettype none
// ============================================================================
// Module      : gray_count_receiver
// Description : Receiving end of a gray-coded counter crossing. The gray count
//               arrives from an unrelated clock domain, passes through a
//               SYNC_STAGES-deep flop synchronizer, is converted to binary and
//               every observed change is checked. A +1 step (mod 2^LENGTH)
//               pulses step_o and bumps a saturating total; any other change
//               raises a sticky error and parks the tracker in FAULT until
//               clear_i.
//
// Ports       : clk_i        receiving-domain clock
//               reset_ni     asynchronous active-low reset
//               count_gray_i gray count from the producer (asynchronous)
//               clear_i      synchronous clear of total_o and err_o
//               count_bin_o  last accepted count, binary
//               valid_o      baseline captured, other outputs meaningful
//               step_o       one-cycle pulse per accepted +1 step
//               total_o      saturating count of accepted steps
//               err_o        sticky illegal-transition flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module gray_count_receiver #(
    parameter int LENGTH      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TOTAL_W     = 16
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [LENGTH-1:0]  count_gray_i,
    input  logic               clear_i,
    output logic [LENGTH-1:0]  count_bin_o,
    output logic               valid_o,
    output logic               step_o,
    output logic [TOTAL_W-1:0] total_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int                   c_FILL_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [c_FILL_W-1:0]  c_FILL_LAST = c_FILL_W'(SYNC_STAGES);
    localparam logic [TOTAL_W-1:0]   c_TOTAL_MAX = '1;
    localparam logic [LENGTH-1:0]    c_ONE       = LENGTH'(1);

    // ------------------------------------------------------------------
    // Synchronizer: plain flop chain, nothing between the stages.
    // ------------------------------------------------------------------
    logic [LENGTH-1:0] r_sync [SYNC_STAGES];

    generate
        for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
            if (i == 0) begin : g_first
                always_ff @(posedge clk_i or negedge reset_ni) begin
                    if (!reset_ni) r_sync[i] <= '0;
                    else           r_sync[i] <= count_gray_i;
                end
            end else begin : g_next
                always_ff @(posedge clk_i or negedge reset_ni) begin
                    if (!reset_ni) r_sync[i] <= '0;
                    else           r_sync[i] <= r_sync[i-1];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Gray to binary: each binary bit is the XOR of all gray bits at or
    // above its position.
    // ------------------------------------------------------------------
    logic [LENGTH-1:0] w_sync_gray;
    logic [LENGTH-1:0] w_sync_bin;

    assign w_sync_gray = r_sync[SYNC_STAGES-1];

    generate
        for (genvar b = 0; b < LENGTH; b++) begin : g_g2b
            assign w_sync_bin[b] = ^w_sync_gray[LENGTH-1:b];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tracker state and registered outputs
    // ------------------------------------------------------------------
    state_t             r_state,    w_state_nxt;
    logic [c_FILL_W-1:0] r_fill_cnt, w_fill_nxt;
    logic [LENGTH-1:0]  r_prev,     w_prev_nxt;
    logic               r_valid,    w_valid_nxt;
    logic               r_step,     w_step_nxt;
    logic [TOTAL_W-1:0] r_total,    w_total_nxt;
    logic               r_err,      w_err_nxt;

    logic [LENGTH-1:0]  w_delta;
    logic [TOTAL_W-1:0] w_total_inc;

    // Modular difference: wrap from 2^LENGTH-1 to 0 naturally yields 1.
    assign w_delta     = w_sync_bin - r_prev;
    assign w_total_inc = (r_total == c_TOTAL_MAX) ? r_total : r_total + TOTAL_W'(1);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
            r_prev     <= '0;
            r_valid    <= 1'b0;
            r_step     <= 1'b0;
            r_total    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_prev     <= w_prev_nxt;
            r_valid    <= w_valid_nxt;
            r_step     <= w_step_nxt;
            r_total    <= w_total_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_prev_nxt  = r_prev;
        w_valid_nxt = r_valid;
        w_step_nxt  = 1'b0;
        w_total_nxt = r_total;
        w_err_nxt   = r_err;

        case (r_state)
            ST_FILL: begin
                // Wait until the whole synchronizer holds post-reset samples,
                // then take the synchronized value as the baseline.
                if (r_fill_cnt == c_FILL_LAST) begin
                    w_prev_nxt  = w_sync_bin;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_TRACK;
                end else begin
                    w_fill_nxt = r_fill_cnt + c_FILL_W'(1);
                end
            end

            ST_TRACK: begin
                if (w_delta == c_ONE) begin
                    w_step_nxt  = 1'b1;
                    w_prev_nxt  = w_sync_bin;
                    w_total_nxt = w_total_inc;
                end else if (w_delta != '0) begin
                    w_err_nxt   = 1'b1;
                    w_prev_nxt  = w_sync_bin;
                    w_state_nxt = ST_FAULT;
                end
                // Clear wins over a same-cycle step; the pulse still fires.
                if (clear_i) begin
                    w_total_nxt = '0;
                end
            end

            ST_FAULT: begin
                // Re-baseline continuously so a clear resumes from the
                // current producer value rather than the faulting one.
                w_prev_nxt = w_sync_bin;
                if (clear_i) begin
                    w_err_nxt   = 1'b0;
                    w_total_nxt = '0;
                    w_state_nxt = ST_TRACK;
                end
            end

            default: begin
                w_state_nxt = ST_FILL;
                w_fill_nxt  = '0;
            end
        endcase
    end

    assign count_bin_o = r_prev;
    assign valid_o     = r_valid;
    assign step_o      = r_step;
    assign total_o     = r_total;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_count_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_count_receiver
// Description : Self-checking bench for gray_count_receiver. Stimulus pushes
//               expected step/error events (value, total, due cycle) into a
//               scoreboard; a negedge monitor pops and compares whenever the
//               DUT pulses step_o or raises err_o. A second instance with
//               TOTAL_W=4 exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_count_receiver;

    localparam int LEN  = 3;
    localparam int SYNC = 2;
    localparam int MAXT = 65535;

    logic           clk = 1'b0;
    logic           reset_ni;
    logic [LEN-1:0] count_gray_i;
    logic           clear_i;

    logic [LEN-1:0] count_bin_o,  count_bin4;
    logic           valid_o,      valid4;
    logic           step_o,       step4;
    logic [15:0]    total_o;
    logic [3:0]     total4;
    logic           err_o,        err4;

    always #5 clk = ~clk;

    gray_count_receiver #(.LENGTH(LEN), .SYNC_STAGES(SYNC), .TOTAL_W(16)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .count_gray_i(count_gray_i), .clear_i(clear_i),
        .count_bin_o(count_bin_o), .valid_o(valid_o), .step_o(step_o),
        .total_o(total_o), .err_o(err_o)
    );

    gray_count_receiver #(.LENGTH(LEN), .SYNC_STAGES(SYNC), .TOTAL_W(4)) dut4 (
        .clk_i(clk), .reset_ni(reset_ni), .count_gray_i(count_gray_i), .clear_i(clear_i),
        .count_bin_o(count_bin4), .valid_o(valid4), .step_o(step4),
        .total_o(total4), .err_o(err4)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_steps  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int is_err;
        int bin;
        int total;
        int due;
    } ev_t;

    ev_t sb[$];

    // Reference model state: last accepted value, step total, fault flag,
    // and the value currently presented to the DUT.
    int m_prev, m_total, m_in;
    bit m_fault;

    function automatic int b2g(int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit prev_err = 1'b0;

    always @(negedge clk) begin
        if (reset_ni && valid_o) begin
            if (step_o || (err_o && !prev_err)) begin
                if (step_o) n_steps++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual step=%0d err=%0d required=none (t=%0t)",
                             step_o, err_o, $time);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("ev_kind", step_o ? 0 : 1, e.is_err);
                    chk("ev_bin", count_bin_o, e.bin);
                    chk("ev_cycle", cyc, e.due);
                    if (e.is_err == 0) chk("ev_total", total_o, e.total);
                end
            end
        end
        prev_err = err_o;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Present a new binary value (as gray) and hold it for 'hold' cycles.
    // With clr_at_step, clear_i is asserted on the edge that accepts the step.
    task automatic drive(int v, int hold, bit clr_at_step = 1'b0);
        int d;
        @(posedge clk);
        #1;
        count_gray_i = LEN'(b2g(v));
        m_in = v;
        d = (v - m_prev) & ((1 << LEN) - 1);
        if (m_fault) begin
            m_prev = v;
        end else if (d == 1) begin
            if (clr_at_step)        m_total = 0;
            else if (m_total < MAXT) m_total = m_total + 1;
            sb.push_back('{0, v, m_total, cyc + 1 + SYNC});
            m_prev = v;
        end else if (d != 0) begin
            sb.push_back('{1, v, 0, cyc + 1 + SYNC});
            m_fault = 1'b1;
            m_prev  = v;
        end
        if (clr_at_step) begin
            @(posedge clk);
            @(posedge clk);
            #1 clear_i = 1'b1;
            @(posedge clk);
            #1 clear_i = 1'b0;
        end else begin
            repeat (hold - 1) @(posedge clk);
        end
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1 clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
        m_total = 0;
        m_fault = 1'b0;
        chk("clear_err", err_o, 0);
        chk("clear_total", total_o, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic settle();
        repeat (SYNC + 1) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int v0);
        clear_i      = 1'b0;
        count_gray_i = LEN'(b2g(v0));
        m_in         = v0;
        reset_ni     = 1'b0;
        #1;
        chk("rst_now_total", total_o, 0);
        chk("rst_now_valid", valid_o, 0);
        chk("rst_now_bin", count_bin_o, 0);
        chk("rst_now_err", err_o, 0);
        chk("rst_now_step", step_o, 0);
        chk("rst_now_total4", total4, 0);
        sb.delete();
        m_prev  = v0;
        m_total = 0;
        m_fault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", valid_o, 0);
        reset_ni = 1'b1;
        @(posedge clk); #1;
        chk("fill_e1_valid", valid_o, 0);
        @(posedge clk); #1;
        chk("fill_e2_valid", valid_o, 0);
        @(posedge clk); #1;
        chk("fill_e3_valid", valid_o, 1);
        chk("fill_e3_bin", count_bin_o, v0);
        chk("fill_e3_step", step_o, 0);
        chk("fill_e3_err", err_o, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n0;
        int nb;
        reset_ni     = 1'b1;
        clear_i      = 1'b0;
        count_gray_i = '0;
        m_prev = 0; m_total = 0; m_fault = 1'b0; m_in = 0;
        #2;

        // Baseline capture with 3'b110 held through reset.
        do_reset(4);

        // Full wrap of the counter, one step every two cycles.
        do_reset(0);
        n0 = n_steps;
        for (int i = 1; i <= 8; i++) drive(i % 8, 2);
        wait_drain();
        chk("wrap_steps", n_steps - n0, 8);
        chk("wrap_total", total_o, 8);
        chk("wrap_bin", count_bin_o, 0);
        chk("wrap_err", err_o, 0);

        // Multi-bit jump 1 -> 4, follow to 5, clear, then a legal step.
        drive(1, 3);
        drive(4, 3);
        wait_drain();
        chk("jump_err", err_o, 1);
        drive(5, 3);
        settle();
        chk("fault_total_frozen", total_o, 9);
        chk("fault_bin_follow", count_bin_o, 5);
        do_clear();
        drive(6, 3);
        wait_drain();
        chk("post_clear_total", total_o, 1);
        chk("post_clear_err", err_o, 0);

        // Single-bit decrement 2 -> 1 is illegal.
        for (int v = 7; v <= 10; v++) drive(v % 8, 3);
        drive(1, 3);
        wait_drain();
        chk("dec_err", err_o, 1);
        chk("dec_bin", count_bin_o, 1);
        do_clear();

        // Clear coincident with an accepted step at total 5.
        for (int v = 2; v <= 6; v++) drive(v, 3);
        wait_drain();
        chk("pre_clrstep_total", total_o, 5);
        drive(7, 4, 1'b1);
        wait_drain();
        chk("clrstep_total", total_o, 0);

        // Randomized mix of steps, holds, jumps and clears.
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 80)      nb = (m_in + 1) % 8;
            else if (r < 88) nb = m_in;
            else             nb = int'($urandom_range(0, 7));
            drive(nb, int'($urandom_range(3, 5)));
            if (m_fault && ($urandom_range(0, 2) == 0)) do_clear();
        end
        wait_drain();
        chk("rand_total", total_o, m_total);
        chk("rand_err", err_o, m_fault ? 1 : 0);
        chk("rand_bin", count_bin_o, m_prev);

        // Saturation on the narrow instance, then reset mid-sequence.
        do_reset(0);
        for (int i = 1; i <= 20; i++) drive(i % 8, 2);
        wait_drain();
        chk("sat_total4", total4, 15);
        chk("sat_err4", err4, 0);
        chk("sat_total16", total_o, 20);
        drive(5, 2);
        #3;
        do_reset(3);
        drive(4, 3);
        wait_drain();
        chk("after_reset_total", total_o, 1);
        chk("after_reset_bin", count_bin_o, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
